// File: rtl/shifter_ctrl_pkg.sv
// shifter_ctrl_pkg
//   Shared definitions for the memory-interface shifter control blocks:
//   FSM state encoding, default beat-count width and a ceil-log2 helper
//   used to size the rotate-amount field.
package shifter_ctrl_pkg;

  localparam int C_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // ceil(log2(value)), never less than 1 so a one-lane shifter still gets a
  // legal 1-bit control field.
  function automatic int C_LOG_2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shifter_ctrl_register.sv
// shifter_ctrl_register
//   Holding registers for the command: the rotate amount (kept for the whole
//   command) and the remaining-beat counter.
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   load_i       capture offset_i / count_i (command accept)
//   dec_i        decrement the remaining count by one
//   offset_i     command lane rotation
//   count_i      command beat count
//   offset_o     held rotate amount (offset modulo NUM_DATA)
//   remaining_o  beats still to be loaded
module shifter_ctrl_register #(
  parameter int NUM_DATA    = 16,
  parameter int CTRL_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   dec_i,
  input  logic [CTRL_WIDTH-1:0]  offset_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic [CTRL_WIDTH-1:0]  offset_o,
  output logic [COUNT_WIDTH-1:0] remaining_o
);

  logic [CTRL_WIDTH-1:0]  offset_q, offset_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

  always_comb begin
    offset_d    = offset_q;
    remaining_d = remaining_q;
    if (load_i) begin
      offset_d    = CTRL_WIDTH'(32'(offset_i) % NUM_DATA);
      remaining_d = count_i;
    end else if (dec_i && (remaining_q != '0)) begin
      // Saturate at zero: the counter never wraps.
      remaining_d = remaining_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      offset_q    <= '0;
      remaining_q <= '0;
    end else begin
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
    end
  end

  assign offset_o    = offset_q;
  assign remaining_o = remaining_q;

endmodule

// File: rtl/shifter_ctrl.sv
// shifter_ctrl
//   Control FSM for a lane-rotating shifter fed from memory reads. Accepts
//   one command (offset, beat count), strobes the shifter input registers
//   once per memory beat while keeping the one-register shifter output
//   stage from being overwritten, and flags the last beat and completion.
// Ports
//   ACLK           clock, rising edge
//   RESET          synchronous active-high reset
//   CMD_VALID/READY, CMD_OFFSET, CMD_NUM_BEATS   command handshake
//   IN_VALID/READY memory read beat handshake
//   SHIFT_RD_EN    shifter input load strobe
//   SHIFT_CTRL     shifter rotate amount
//   OUT_VALID/READY/LAST   aligned beat handshake from the shifter
//   DONE           one-cycle completion pulse
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | ready for a command (held off for the DONE cycle)
// ST_STREAM | loading beats; remaining > 0
// ST_DRAIN  | all beats loaded; waiting for the last beat to be accepted
module shifter_ctrl
  import shifter_ctrl_pkg::*;
#(
  parameter int NUM_DATA    = 16,
  parameter int CTRL_WIDTH  = C_LOG_2(NUM_DATA),
  parameter int COUNT_WIDTH = C_COUNT_WIDTH
) (
  input  logic                   ACLK,
  input  logic                   RESET,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [CTRL_WIDTH-1:0]  CMD_OFFSET,
  input  logic [COUNT_WIDTH-1:0] CMD_NUM_BEATS,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic                   SHIFT_RD_EN,
  output logic [CTRL_WIDTH-1:0]  SHIFT_CTRL,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OUT_LAST,
  output logic                   DONE
);

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic   out_last_q, out_last_d;
  logic   done_q, done_d;
  logic   cmd_ready;
  logic   cmd_accept;
  logic   load;
  logic [COUNT_WIDTH-1:0] remaining;

  shifter_ctrl_register #(
    .NUM_DATA   (NUM_DATA),
    .CTRL_WIDTH (CTRL_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_register (
    .clk_i      (ACLK),
    .rst_i      (RESET),
    .load_i     (cmd_accept),
    .dec_i      (load),
    .offset_i   (CMD_OFFSET),
    .count_i    (CMD_NUM_BEATS),
    .offset_o   (SHIFT_CTRL),
    .remaining_o(remaining)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    cmd_accept  = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Not ready while DONE is showing, so a back-to-back command is
        // only taken once the previous completion has been signalled.
        cmd_ready = !done_q && !RESET;
        if (cmd_ready && CMD_VALID) begin
          cmd_accept = 1'b1;
          if (CMD_NUM_BEATS == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        // Load only when the output stage is empty or being emptied now.
        load = IN_VALID && (!out_valid_q || OUT_READY) && !RESET;
        if (load) begin
          out_valid_d = 1'b1;
          if (remaining == COUNT_WIDTH'(1)) begin
            out_last_d = 1'b1;
            state_d    = ST_DRAIN;
          end
        end else if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && OUT_READY && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign CMD_READY   = cmd_ready;
  assign IN_READY    = load;
  assign SHIFT_RD_EN = load;
  assign OUT_VALID   = out_valid_q;
  assign OUT_LAST    = out_last_q;
  assign DONE        = done_q;

endmodule

// File: tb/tb_shifter_ctrl.sv
module tb_shifter_ctrl;

  localparam int NUM_DATA = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_offset;
  logic [15:0] cmd_nb;
  logic        in_valid;
  logic        in_ready;
  logic        rd_en;
  logic [3:0]  shift_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;

  always #5 clk = ~clk;

  shifter_ctrl dut (
    .ACLK         (clk),
    .RESET        (rst),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_OFFSET   (cmd_offset),
    .CMD_NUM_BEATS(cmd_nb),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .SHIFT_RD_EN  (rd_en),
    .SHIFT_CTRL   (shift_ctrl),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .OUT_LAST     (out_last),
    .DONE         (done)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Stand-in for the shifter datapath: each memory beat carries its index
  // within the command, so the beat held at the output shows its order.
  logic [15:0] mem_idx;
  logic [15:0] sh_q;
  always @(posedge clk) begin
    if (rd_en) sh_q <= mem_idx;
    if (cmd_ready && cmd_valid) mem_idx <= 16'd0;
    else if (in_ready) mem_idx <= mem_idx + 16'd1;
  end

  // Transaction-level model: a command in flight, beats left to fetch,
  // whether a beat sits in the shifter, and a pending completion flag.
  bit m_valid = 0;
  bit m_busy  = 0;
  bit m_hold  = 0;
  bit m_last  = 0;
  bit m_done  = 0;
  int m_left  = 0;
  int m_nb    = 0;
  int m_off   = 0;
  int m_idx   = 0;
  int cnt_load = 0, cnt_acc = 0, cnt_last = 0, cnt_done = 0;

  always @(negedge clk) begin
    bit e_ready, e_load, acc, dn;
    e_ready = !rst && !m_busy && !m_done;
    e_load  = !rst && m_busy && (m_left > 0) && in_valid && (!m_hold || out_ready);
    if (m_valid) begin
      check("cmd_ready",   int'(cmd_ready),  int'(e_ready));
      check("shift_rd_en", int'(rd_en),      int'(e_load));
      check("in_ready",    int'(in_ready),   int'(e_load));
      check("out_valid",   int'(out_valid),  int'(m_hold));
      check("out_last",    int'(out_last),   int'(m_hold && m_last));
      check("done",        int'(done),       int'(m_done));
      check("shift_ctrl",  int'(shift_ctrl), m_off);
      if (m_hold) check("beat_order", int'(sh_q), m_idx);
    end
    if (rd_en) cnt_load++;
    if (out_valid && out_ready) cnt_acc++;
    if (out_valid && out_ready && out_last) cnt_last++;
    if (done) cnt_done++;

    if (rst) begin
      m_valid = 1; m_busy = 0; m_hold = 0; m_last = 0; m_done = 0;
      m_left = 0; m_off = 0;
    end else begin
      acc = m_hold && out_ready;
      dn  = 0;
      if (e_ready && cmd_valid) begin
        m_off = int'(cmd_offset) % NUM_DATA;
        if (cmd_nb == 16'd0) dn = 1;
        else begin
          m_busy = 1; m_left = int'(cmd_nb); m_nb = int'(cmd_nb);
        end
      end else if (e_load) begin
        m_idx  = m_nb - m_left;
        m_left = m_left - 1;
        m_hold = 1;
        m_last = (m_left == 0);
      end else if (acc) begin
        m_hold = 0;
        if (m_last) begin
          m_last = 0; m_busy = 0; dn = 1;
        end
      end
      m_done = dn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for DONE; thresh>0 randomises IN_VALID/OUT_READY each cycle with
  // probability thresh/32 of being high.
  task automatic wait_done(input int budget, input string name, input int thresh);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (thresh > 0) begin
        in_valid  = ($urandom_range(0, 31) < thresh);
        out_ready = ($urandom_range(0, 31) < thresh);
      end
      #1;
      if (done) seen = 1;
    end
    check({name, " done_seen"}, int'(seen), 1);
  endtask

  initial begin
    int l0, a0, t0, d0;
    bit seen;
    rst = 1; cmd_valid = 0; cmd_offset = 0; cmd_nb = 0; in_valid = 0; out_ready = 0;
    repeat (3) tick();
    #1;
    check("rst cmd_ready", int'(cmd_ready), 0);
    check("rst rd_en",     int'(rd_en),     0);
    tick(); rst = 0; #1;
    check("reset out_valid",  int'(out_valid),  0);
    check("reset done",       int'(done),       0);
    check("reset shift_ctrl", int'(shift_ctrl), 0);
    check("reset cmd_ready",  int'(cmd_ready),  1);

    // Offset 3, 4 beats, full throughput.
    tick(); cmd_valid = 1; cmd_offset = 4'd3; cmd_nb = 16'd4; in_valid = 1; out_ready = 1; #1;
    check("t1 accept ready", int'(cmd_ready), 1);
    for (int k = 1; k <= 7; k++) begin
      tick(); cmd_valid = 0; #1;
      check("t1 rd_en",     int'(rd_en),      int'(k >= 1 && k <= 4));
      check("t1 out_valid", int'(out_valid),  int'(k >= 2 && k <= 5));
      check("t1 out_last",  int'(out_last),   int'(k == 5));
      check("t1 done",      int'(done),       int'(k == 6));
      check("t1 cmd_ready", int'(cmd_ready),  int'(k == 7));
      check("t1 shift_ctrl", int'(shift_ctrl), 3);
    end

    // 3 beats, output stalled for 5 cycles after the first beat.
    tick(); cmd_valid = 1; cmd_offset = 4'd9; cmd_nb = 16'd3; in_valid = 1; out_ready = 1;
    tick(); cmd_valid = 0; out_ready = 0; #1;
    check("t2 first load", int'(rd_en), 1);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check("t2 stall rd_en",    int'(rd_en),     0);
      check("t2 stall in_ready", int'(in_ready),  0);
      check("t2 stall valid",    int'(out_valid), 1);
      check("t2 held beat",      int'(sh_q),      0);
    end
    tick(); out_ready = 1;
    wait_done(20, "t2", 0);

    // Zero-beat command.
    tick(); cmd_valid = 1; cmd_offset = 4'd5; cmd_nb = 16'd0; in_valid = 1; out_ready = 1;
    tick(); cmd_valid = 0; #1;
    check("t3 done",      int'(done),      1);
    check("t3 cmd_ready", int'(cmd_ready), 0);
    check("t3 rd_en",     int'(rd_en),     0);
    check("t3 out_valid", int'(out_valid), 0);
    tick(); #1;
    check("t3 done clr",   int'(done),       0);
    check("t3 ready back", int'(cmd_ready),  1);
    check("t3 rd_en2",     int'(rd_en),      0);
    check("t3 shift_ctrl", int'(shift_ctrl), 5);

    // Second command offered while streaming.
    tick(); cmd_valid = 1; cmd_offset = 4'd2; cmd_nb = 16'd2; in_valid = 0; out_ready = 1;
    tick(); cmd_offset = 4'd7; cmd_nb = 16'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4 busy ready", int'(cmd_ready),  0);
      check("t4 offset held", int'(shift_ctrl), 2);
      tick();
    end
    in_valid = 1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(); #1;
      if (done) begin
        seen = 1;
        check("t4 ready in done", int'(cmd_ready), 0);
      end
    end
    check("t4 done_seen", int'(seen), 1);
    tick(); #1;
    check("t4 second accept", int'(cmd_ready), 1);
    tick(); cmd_valid = 0; #1;
    check("t4 new offset", int'(shift_ctrl), 7);
    wait_done(20, "t4b", 0);

    // Reset after 2 of 6 beats, then a 1-beat command at offset 15.
    tick(); cmd_valid = 1; cmd_offset = 4'd4; cmd_nb = 16'd6; in_valid = 1; out_ready = 1;
    tick(); cmd_valid = 0;
    tick();
    tick(); rst = 1; #1;
    check("t5 rst rd_en",     int'(rd_en),     0);
    check("t5 rst in_ready",  int'(in_ready),  0);
    check("t5 rst cmd_ready", int'(cmd_ready), 0);
    tick(); rst = 0; #1;
    check("t5 out_valid", int'(out_valid), 0);
    check("t5 done",      int'(done),      0);
    check("t5 ready",     int'(cmd_ready), 1);
    cmd_valid = 1; cmd_offset = 4'd15; cmd_nb = 16'd1;
    tick(); cmd_valid = 0;
    wait_done(10, "t5", 0);
    check("t5 offset15", int'(shift_ctrl), 15);

    // Random commands, handshakes and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      tick();
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_offset = 4'($urandom);
      cmd_nb     = 16'($urandom_range(0, 6));
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 199) == 0);
    end
    tick(); rst = 0; cmd_valid = 0; in_valid = 1; out_ready = 1;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick(); #1;
      if (cmd_ready) seen = 1;
    end
    check("t6 back to idle", int'(seen), 1);

    // Maximum-length command with random handshakes.
    l0 = cnt_load; a0 = cnt_acc; t0 = cnt_last; d0 = cnt_done;
    cmd_valid = 1; cmd_offset = 4'($urandom); cmd_nb = 16'hFFFF;
    tick(); cmd_valid = 0;
    wait_done(90000, "t7", 31);
    tick(); tick();
    check("t7 loads",   cnt_load - l0, 65535);
    check("t7 accepts", cnt_acc - a0,  65535);
    check("t7 lasts",   cnt_last - t0, 1);
    check("t7 dones",   cnt_done - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
